// File: rtl/pulse_gen_pkg.sv
// Shared types and helpers for the multi-channel pulse generator.
package pulse_gen_pkg;

   typedef enum logic {
      MODE_ONESHOT  = 1'b0,
      MODE_PERIODIC = 1'b1
   } mode_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DELAY = 2'd1,
      ST_PULSE = 2'd2
   } state_e;

   // Zero is clamped to one so a zero delay/width never means "forever".
   function automatic logic [63:0] clamp_min1(input logic [63:0] v);
      return (v == 64'd0) ? 64'd1 : v;
   endfunction

endpackage

// File: rtl/pulse_gen_channel.sv
// One pulse channel: FSM, delay/width counters, active config and output registers.
module pulse_gen_channel
   import pulse_gen_pkg::*;
#(
   parameter int CNT_W = 32,
   parameter int PW_W  = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             stop,
   input  logic [CNT_W-1:0] sh_delay,
   input  logic [PW_W-1:0]  sh_width,
   input  mode_e            sh_mode,
   output logic             pulse_out,
   output logic             busy,
   output logic             done
);

   state_e             state;
   mode_e              mode_q;
   logic [CNT_W-1:0]   dly_q;
   logic [CNT_W-1:0]   dcnt;
   logic [PW_W-1:0]    wid_q;
   logic [PW_W-1:0]    wcnt;

   // Counters run 1..limit and compare against the latched limit, so the
   // largest representable delay is exact and nothing ever wraps.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         mode_q    <= MODE_ONESHOT;
         dly_q     <= '0;
         dcnt      <= '0;
         wid_q     <= '0;
         wcnt      <= '0;
         pulse_out <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start && !stop) begin
                  dly_q  <= CNT_W'(clamp_min1(64'(sh_delay)));
                  wid_q  <= PW_W'(clamp_min1(64'(sh_width)));
                  mode_q <= sh_mode;
                  dcnt   <= CNT_W'(1);
                  busy   <= 1'b1;
                  state  <= ST_DELAY;
               end
            end
            ST_DELAY: begin
               if (stop) begin
                  state     <= ST_IDLE;
                  busy      <= 1'b0;
                  pulse_out <= 1'b0;
               end else if (dcnt == dly_q) begin
                  wcnt      <= PW_W'(1);
                  pulse_out <= 1'b1;
                  state     <= ST_PULSE;
               end else begin
                  dcnt <= dcnt + CNT_W'(1);
               end
            end
            ST_PULSE: begin
               if (stop) begin
                  state     <= ST_IDLE;
                  busy      <= 1'b0;
                  pulse_out <= 1'b0;
               end else if (wcnt == wid_q) begin
                  pulse_out <= 1'b0;
                  if (mode_q == MODE_PERIODIC) begin
                     dcnt  <= CNT_W'(1);
                     state <= ST_DELAY;
                  end else begin
                     busy  <= 1'b0;
                     done  <= 1'b1;
                     state <= ST_IDLE;
                  end
               end else begin
                  wcnt <= wcnt + PW_W'(1);
               end
            end
            default: begin
               state     <= ST_IDLE;
               busy      <= 1'b0;
               pulse_out <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: rtl/multi_pulse_generator.sv
// N_CH independent programmable pulse channels with per-channel shadow config.
module multi_pulse_generator
   import pulse_gen_pkg::*;
#(
   parameter int  N_CH  = 4,
   parameter int  CNT_W = 32,
   parameter int  PW_W  = 16,
   localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cfg_we,
   input  logic [CH_W-1:0]  cfg_ch,
   input  logic [CNT_W-1:0] cfg_delay,
   input  logic [PW_W-1:0]  cfg_width,
   input  logic             cfg_mode,
   input  logic [N_CH-1:0]  start,
   input  logic [N_CH-1:0]  stop,
   output logic [N_CH-1:0]  pulse_out,
   output logic [N_CH-1:0]  busy,
   output logic [N_CH-1:0]  done
);

   logic [N_CH-1:0][CNT_W-1:0] sh_delay;
   logic [N_CH-1:0][PW_W-1:0]  sh_width;
   mode_e                      sh_mode [N_CH];

   // Only indices below N_CH are decoded, so out-of-range writes fall through.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int c = 0; c < N_CH; c++) begin
            sh_delay[c] <= '0;
            sh_width[c] <= '0;
            sh_mode[c]  <= MODE_ONESHOT;
         end
      end else if (cfg_we) begin
         for (int c = 0; c < N_CH; c++) begin
            if (cfg_ch == CH_W'(c)) begin
               sh_delay[c] <= cfg_delay;
               sh_width[c] <= cfg_width;
               sh_mode[c]  <= mode_e'(cfg_mode);
            end
         end
      end
   end

   for (genvar g = 0; g < N_CH; g++) begin : g_ch
      pulse_gen_channel #(
         .CNT_W (CNT_W),
         .PW_W  (PW_W)
      ) u_ch (
         .clk       (clk),
         .rst_n     (rst_n),
         .start     (start[g]),
         .stop      (stop[g]),
         .sh_delay  (sh_delay[g]),
         .sh_width  (sh_width[g]),
         .sh_mode   (sh_mode[g]),
         .pulse_out (pulse_out[g]),
         .busy      (busy[g]),
         .done      (done[g])
      );
   end

endmodule

// File: tb/tb_multi_pulse_generator.sv
// Directed bench for multi_pulse_generator: 4-channel 32-bit instance plus a 1-channel 8-bit instance.
module tb_multi_pulse_generator;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        cfg_we = 1'b0;
   logic [1:0]  cfg_ch = '0;
   logic [31:0] cfg_delay = '0;
   logic [15:0] cfg_width = '0;
   logic        cfg_mode = 1'b0;
   logic [3:0]  start = '0;
   logic [3:0]  stop = '0;
   logic [3:0]  pulse_out, busy, done;

   logic        cfg8_we = 1'b0;
   logic [0:0]  cfg8_ch = '0;
   logic [7:0]  cfg8_delay = '0;
   logic [7:0]  cfg8_width = '0;
   logic        cfg8_mode = 1'b0;
   logic [0:0]  start8 = '0;
   logic [0:0]  stop8 = '0;
   logic [0:0]  pulse8, busy8, done8;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   multi_pulse_generator #(.N_CH(4), .CNT_W(32), .PW_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
      .cfg_delay(cfg_delay), .cfg_width(cfg_width), .cfg_mode(cfg_mode),
      .start(start), .stop(stop), .pulse_out(pulse_out), .busy(busy), .done(done)
   );

   multi_pulse_generator #(.N_CH(1), .CNT_W(8), .PW_W(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .cfg_we(cfg8_we), .cfg_ch(cfg8_ch),
      .cfg_delay(cfg8_delay), .cfg_width(cfg8_width), .cfg_mode(cfg8_mode),
      .start(start8), .stop(stop8), .pulse_out(pulse8), .busy(busy8), .done(done8)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // {pulse_out, busy, done} of one channel
   function automatic logic [31:0] code(input int ch);
      return {29'd0, pulse_out[ch], busy[ch], done[ch]};
   endfunction

   // Reference one-shot behaviour k edges after the start edge.
   function automatic logic [31:0] oneshot_exp(input int k, input int dp, input int wp);
      logic p, b, d;
      p = (k >= dp) && (k < dp + wp);
      b = (k < dp + wp);
      d = (k == dp + wp);
      return {29'd0, p, b, d};
   endfunction

   task automatic cfg(input int ch, input int d, input int w, input logic m);
      cfg_we    = 1'b1;
      cfg_ch    = 2'(ch);
      cfg_delay = 32'(d);
      cfg_width = 16'(w);
      cfg_mode  = m;
      tick();
      cfg_we    = 1'b0;
   endtask

   initial begin
      // reset
      #2 rst_n = 1'b0;
      #1;
      check("rst_pulse", 32'(pulse_out), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst8", {29'd0, pulse8, busy8, done8}, 32'd0);
      tick(); tick();
      rst_n = 1'b1;

      // ch0 D=15 W=1 one-shot
      cfg(0, 15, 1, 1'b0);
      start = 4'b0001; tick(); start = '0;
      check("t1_k0", code(0), oneshot_exp(0, 15, 1));
      for (int k = 1; k <= 17; k++) begin
         tick();
         check($sformatf("t1_k%0d", k), code(0), oneshot_exp(k, 15, 1));
      end

      // ch0 D=0 W=0 clamps to 1/1; restart held from the busy edge
      cfg(0, 0, 0, 1'b0);
      start = 4'b0001; tick(); start = '0;
      check("t2_k0", code(0), 32'b010);
      tick(); check("t2_k1", code(0), 32'b110);
      start = 4'b0001;
      tick(); check("t2_k2_ignored", code(0), 32'b001);
      tick(); check("t2_k3_accept", code(0), 32'b010);
      start = '0;
      tick(); check("t2_k4", code(0), 32'b110);
      tick(); check("t2_k5", code(0), 32'b001);
      tick(); check("t2_k6", code(0), 32'b000);

      // ch1 D=3 W=2 periodic, stop mid-pulse
      cfg(1, 3, 2, 1'b1);
      start = 4'b0010; tick(); start = '0;
      for (int k = 1; k <= 23; k++) begin
         tick();
         check($sformatf("t3_k%0d", k), code(1),
               {29'd0, (k >= 3) && (((k - 3) % 5) < 2), 1'b1, 1'b0});
      end
      stop = 4'b0010; tick(); stop = '0;
      check("t3_stop", code(1), 32'b000);
      tick();
      check("t3_after_stop", code(1), 32'b000);

      // ch2 D=10 W=4; rewrite shadow and re-start mid-run
      cfg(2, 10, 4, 1'b0);
      start = 4'b0100; tick(); start = '0;
      tick(); tick(); tick();
      cfg(2, 2, 1, 1'b0);
      start = 4'b0100; tick(); start = '0;
      check("t4_k5", code(2), oneshot_exp(5, 10, 4));
      for (int k = 6; k <= 15; k++) begin
         tick();
         check($sformatf("t4_k%0d", k), code(2), oneshot_exp(k, 10, 4));
      end
      start = 4'b0100; tick(); start = '0;
      for (int k = 1; k <= 4; k++) begin
         tick();
         check($sformatf("t4_new_k%0d", k), code(2), oneshot_exp(k, 2, 1));
      end

      // all channels together, D=5..8 W=2
      for (int c = 0; c < 4; c++) cfg(c, 5 + c, 2, 1'b0);
      start = 4'b1111; tick(); start = '0;
      for (int k = 1; k <= 11; k++) begin
         tick();
         for (int c = 0; c < 4; c++)
            check($sformatf("t5_ch%0d_k%0d", c, k), code(c), oneshot_exp(k, 5 + c, 2));
      end
      start = 4'b1000; stop = 4'b1000; tick(); start = '0; stop = '0;
      check("t5_startstop", code(3), 32'b000);
      tick();
      check("t5_startstop_2", code(3), 32'b000);

      // async reset during DELAY
      cfg(1, 20, 3, 1'b0);
      start = 4'b0010; tick(); start = '0;
      tick(); tick();
      check("t6_pre_busy", code(1), 32'b010);
      #2 rst_n = 1'b0;
      #1;
      check("t6_delay_async", 32'({pulse_out, busy, done}), 32'd0);
      tick(); rst_n = 1'b1;

      // async reset during PULSE
      cfg(1, 2, 5, 1'b0);
      start = 4'b0010; tick(); start = '0;
      tick(); tick(); tick();
      check("t6_pre_pulse", code(1), 32'b110);
      #2 rst_n = 1'b0;
      #1;
      check("t6_pulse_async", 32'({pulse_out, busy, done}), 32'd0);
      tick(); rst_n = 1'b1;

      // shadow is back to zero: clamped 1/1 behaviour
      start = 4'b0010; tick(); start = '0;
      tick(); check("t6_shadow_k1", code(1), 32'b110);
      tick(); check("t6_shadow_k2", code(1), 32'b001);

      // 8-bit variant: out-of-range write dropped, then D=255
      cfg8_we = 1'b1; cfg8_ch = 1'b1; cfg8_delay = 8'd40; cfg8_width = 8'd3;
      tick(); cfg8_we = 1'b0;
      start8 = 1'b1; tick(); start8 = 1'b0;
      tick(); check("t7_oor_k1", {29'd0, pulse8, busy8, done8}, 32'b110);
      tick(); check("t7_oor_k2", {29'd0, pulse8, busy8, done8}, 32'b001);
      cfg8_we = 1'b1; cfg8_ch = 1'b0; cfg8_delay = 8'd255; cfg8_width = 8'd1;
      tick(); cfg8_we = 1'b0;
      start8 = 1'b1; tick(); start8 = 1'b0;
      repeat (254) tick();
      check("t7_k254", {29'd0, pulse8, busy8, done8}, 32'b010);
      tick(); check("t7_k255", {29'd0, pulse8, busy8, done8}, 32'b110);
      tick(); check("t7_k256", {29'd0, pulse8, busy8, done8}, 32'b001);
      tick(); check("t7_k257", {29'd0, pulse8, busy8, done8}, 32'b000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
